prio_code_decoder: RTL and testbench
====================================

Name: prio_code_decoder

Overview:
- Converts a binary priority code from the priority-encoder path back into a timed one-hot strobe. Reverses the encode direction: 2-bit index in, 4-bit one-hot out.
- Each accepted code drives its one-hot line for a programmable hold window, then a programmable idle gap.
- Sits downstream of the priority-encoder stage and feeds per-channel enable or acknowledge lines.
- Uses a valid/ready handshake so upstream stalls while a strobe is in progress.

Parameters:
- IN_W, 2, code width; one-hot output width is 2**IN_W.
- HOLD_CYCLES, 4, cycles the one-hot line stays asserted; legal range 1..255.
- GAP_CYCLES, 1, cycles of all-zero output after each hold; legal range 0..255 (0 = no gap).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  code presented
- in_ready  output  1  block can accept a code this cycle
- in_code  input  IN_W  binary index of the channel to strobe
- in_zero  input  1  encoder "no request" flag; an accepted code with in_zero=1 produces no strobe
- out_onehot  output  2**IN_W  registered one-hot strobe
- out_active  output  1  high while in HOLD with a non-zero strobe
- done  output  1  single-cycle pulse when a transaction completes

Behaviour:
- Reset (async, active-high): state=IDLE, out_onehot=0, out_active=0, done=0, in_ready=0 while rst is high, counter=0. Asserting rst mid-HOLD or mid-GAP clears everything immediately; the in-flight transaction is lost with no done pulse.
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_ready is combinational from state: 1 in IDLE only (base build). Codes offered while in_ready=0 are ignored; upstream must hold them.
- States: IDLE, HOLD, GAP.
- IDLE -> HOLD on transfer:
  - Next cycle out_onehot = in_zero ? 0 : (1 << in_code).
  - out_active = ~in_zero.
  - Counter loads HOLD_CYCLES-1.
  - Latency from accept edge to strobe visible is 1 cycle.
- HOLD: out_onehot is held stable; counter decrements each cycle. When counter==0:
  - If GAP_CYCLES>0: go to GAP, clear out_onehot and out_active, load counter with GAP_CYCLES-1.
  - If GAP_CYCLES==0: go to IDLE, clear outputs, pulse done.
- GAP: out_onehot=0. When counter==0, go to IDLE and pulse done for 1 cycle, coincident with the IDLE cycle.
- Timing: strobe width is exactly HOLD_CYCLES cycles. IDLE re-entry occurs HOLD_CYCLES+GAP_CYCLES cycles after the strobe first appears.
- in_zero transaction: runs the same HOLD/GAP timing with all-zero output, then pulses done. This keeps request pacing uniform.
- Invariant: out_onehot never has more than one bit set.
- Counter width: 8 bits, no wrap; it is only decremented when non-zero.
- Back-to-back: done and in_ready are both high in the IDLE cycle, so a new transfer can be accepted in that same cycle. Minimum period is HOLD_CYCLES+GAP_CYCLES+1 cycles.

Optional Feature:
- Macro: PRIO_CODE_DECODER_SKID_EN.
- When defined:
  - Adds a one-entry request buffer (code + zero flag + full bit).
  - in_ready = IDLE || !buf_full, so one code can be accepted during HOLD or GAP.
  - When the current transaction would return to IDLE and the buffer is full, the FSM enters HOLD directly with the buffered code, pops the buffer, and still pulses done that cycle. There is no IDLE cycle between transactions.
  - A transfer in the same cycle as a pop refills the buffer.
  - rst clears buf_full.
- When not defined: no buffer exists and in_ready is high only in IDLE, as described above.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 -> out_onehot=0000, done=0, in_ready=0; after release, in_ready=1.
- Basic decode (HOLD=4, GAP=1): send code 2'b10, in_zero=0 -> out_onehot=0100 for exactly 4 cycles starting 1 cycle after accept, then 0000 for 1 cycle, then done=1 for 1 cycle with in_ready=1.
- Sweep: codes 00, 01, 10, 11 back-to-back -> strobes 0001, 0010, 0100, 1000 in order; each accepted the cycle done pulses; period 6 cycles; never more than one bit set.
- Zero request: code 00 with in_zero=1 -> out_onehot stays 0000 and out_active=0 for 5 cycles, then done pulses.
- Reset mid-HOLD: accept code 11, assert rst on the 2nd strobe cycle -> out_onehot=0000 immediately (asynchronous), no done pulse, and IDLE after release.
- With PRIO_CODE_DECODER_SKID_EN and GAP=0: offer 01 then 10 consecutively -> second code accepted during HOLD; output is 0010 for 4 cycles then 0100 for 4 cycles with no gap; done pulses at the switch and at the end.

Source files
------------

// File: rtl/prio_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : prio_code_decoder
//  Purpose  : Turns a binary priority code back into a timed one-hot strobe.
//             Each accepted code drives its output line for HOLD_CYCLES cycles,
//             then the output stays all-zero for GAP_CYCLES cycles. A
//             single-cycle done pulse marks the end of every transaction.
//  Ports    : clk        - rising-edge clock
//             rst        - asynchronous active-high reset
//             in_valid   - upstream presents a code
//             in_ready   - block accepts a code this cycle
//             in_code    - binary index of the channel to strobe
//             in_zero    - "no request" flag; the transaction runs with no strobe
//             out_onehot - registered one-hot strobe
//             out_active - high while holding a non-zero strobe
//             done       - one-cycle pulse when a transaction completes
//  Options  : PRIO_CODE_DECODER_SKID_EN - adds a one-entry request buffer so
//             that one code can be accepted during HOLD/GAP and started with
//             no IDLE cycle in between.
//  Revision : 1.0 - initial release
// ============================================================================
module prio_code_decoder #(
  parameter int IN_W        = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  input  logic                 in_zero,
  output logic [2**IN_W-1:0]   out_onehot,
  output logic                 out_active,
  output logic                 done
);

  localparam int         C_OUT_W     = 2**IN_W;
  localparam logic [7:0] C_HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] C_GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [7:0]           r_cnt, w_cnt_nxt;
  logic [C_OUT_W-1:0]   r_onehot, w_onehot_nxt;
  logic                 r_active, w_active_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_xfer;
  logic                 w_finish;

  function automatic logic [C_OUT_W-1:0] f_decode(input logic [IN_W-1:0] code,
                                                  input logic            zero);
    f_decode = zero ? '0 : (C_OUT_W'(1) << code);
  endfunction

`ifdef PRIO_CODE_DECODER_SKID_EN
  logic              r_buf_full;
  logic [IN_W-1:0]   r_buf_code;
  logic              r_buf_zero;
  logic              w_push;
  logic              w_pop;

  assign in_ready = !rst && ((r_state == S_IDLE) || !r_buf_full);
`else
  assign in_ready = !rst && (r_state == S_IDLE);
`endif

  assign w_xfer = in_valid && in_ready;

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_onehot <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_onehot <= w_onehot_nxt;
      r_active <= w_active_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_onehot_nxt = r_onehot;
    w_active_nxt = r_active;
    w_done_nxt   = 1'b0;
    w_finish     = 1'b0;
`ifdef PRIO_CODE_DECODER_SKID_EN
    w_pop        = 1'b0;
    w_push       = 1'b0;
`endif

    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nxt  = S_HOLD;
          w_onehot_nxt = f_decode(in_code, in_zero);
          w_active_nxt = !in_zero;
          w_cnt_nxt    = C_HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (r_cnt == 8'd0) begin
          if (GAP_CYCLES > 0) begin
            w_state_nxt  = S_GAP;
            w_onehot_nxt = '0;
            w_active_nxt = 1'b0;
            w_cnt_nxt    = C_GAP_LOAD;
          end else begin
            w_finish = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_GAP: begin
        w_onehot_nxt = '0;
        w_active_nxt = 1'b0;
        if (r_cnt == 8'd0) begin
          w_finish = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_onehot_nxt = '0;
        w_active_nxt = 1'b0;
        w_cnt_nxt    = 8'd0;
      end
    endcase

    // End of a transaction: done is registered so it lands in the first
    // cycle after the hold/gap window, whatever state follows.
    if (w_finish) begin
      w_done_nxt = 1'b1;
`ifdef PRIO_CODE_DECODER_SKID_EN
      if (r_buf_full) begin
        w_pop        = 1'b1;
        w_state_nxt  = S_HOLD;
        w_onehot_nxt = f_decode(r_buf_code, r_buf_zero);
        w_active_nxt = !r_buf_zero;
        w_cnt_nxt    = C_HOLD_LOAD;
      end else if (w_xfer) begin
        // A code arriving on the very last cycle bypasses the empty buffer
        // so it is never stranded behind an IDLE state.
        w_state_nxt  = S_HOLD;
        w_onehot_nxt = f_decode(in_code, in_zero);
        w_active_nxt = !in_zero;
        w_cnt_nxt    = C_HOLD_LOAD;
      end else
`endif
      begin
        w_state_nxt  = S_IDLE;
        w_onehot_nxt = '0;
        w_active_nxt = 1'b0;
        w_cnt_nxt    = 8'd0;
      end
    end

`ifdef PRIO_CODE_DECODER_SKID_EN
    w_push = w_xfer && (r_state != S_IDLE) && !(w_finish && !r_buf_full);
`endif
  end

`ifdef PRIO_CODE_DECODER_SKID_EN
  // One-entry request buffer; a push in the same cycle as a pop refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_full <= 1'b0;
      r_buf_code <= '0;
      r_buf_zero <= 1'b0;
    end else if (w_push) begin
      r_buf_full <= 1'b1;
      r_buf_code <= in_code;
      r_buf_zero <= in_zero;
    end else if (w_pop) begin
      r_buf_full <= 1'b0;
    end
  end
`endif

  assign out_onehot = r_onehot;
  assign out_active = r_active;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_prio_code_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_code_decoder
//  Purpose  : Self-checking bench for prio_code_decoder. Two instances share
//             the input stream: dut_a (HOLD=4, GAP=1) and dut_b (HOLD=4,
//             GAP=0). A timing model tracks each instance's transactions by
//             their first strobe cycle and predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prio_code_decoder;

  localparam int H  = 4;
  localparam int GA = 1;
  localparam int GB = 0;
`ifdef PRIO_CODE_DECODER_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_code = 2'b00;
  logic       in_zero = 1'b0;
  logic       a_rdy, b_rdy, a_act, b_act, a_done, b_done;
  logic [3:0] a_oh, b_oh;

  always #5 clk = ~clk;

  prio_code_decoder #(.IN_W(2), .HOLD_CYCLES(H), .GAP_CYCLES(GA)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_rdy),
    .in_code(in_code), .in_zero(in_zero), .out_onehot(a_oh),
    .out_active(a_act), .done(a_done));

  prio_code_decoder #(.IN_W(2), .HOLD_CYCLES(H), .GAP_CYCLES(GB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_rdy),
    .in_code(in_code), .in_zero(in_zero), .out_onehot(b_oh),
    .out_active(b_act), .done(b_done));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- timing model ----------------
  // Per instance, the last two transactions: first strobe cycle, code, zero.
  int  m_s[2][2];
  int  m_code[2][2];
  bit  m_zero[2][2];
  bit  m_has[2][2];
  int  m_gap[2] = '{GA, GB};

  function automatic void model_exp(input int id, input int n, output logic rdy,
                                    output logic [3:0] oh, output logic act,
                                    output logic dn);
    int le;
    bit pend;
    rdy = 1'b0; oh = 4'b0000; act = 1'b0; dn = 1'b0;
    if (rst) return;
    le   = m_has[id][1] ? m_s[id][1] + H + m_gap[id] : -1000;
    pend = m_has[id][1] && (m_s[id][1] > n);
    rdy  = (n >= le) || (SKID && !pend);
    for (int j = 0; j < 2; j++) begin
      if (m_has[id][j]) begin
        if (n >= m_s[id][j] && n < m_s[id][j] + H && !m_zero[id][j]) begin
          oh  = 4'b0001 << m_code[id][j];
          act = 1'b1;
        end
        if (m_s[id][j] + H + m_gap[id] == n) dn = 1'b1;
      end
    end
  endfunction

  // Continuous checker at the falling edge
  initial begin
    logic       e_rdy, e_act, e_dn;
    logic [3:0] e_oh;
    int         le;
    for (int i = 0; i < 2; i++) begin
      m_has[i][0] = 1'b0;
      m_has[i][1] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        model_exp(id, cyc, e_rdy, e_oh, e_act, e_dn);
        chk(id == 0 ? "a_onehot" : "b_onehot", {28'd0, id == 0 ? a_oh : b_oh}, {28'd0, e_oh});
        chk(id == 0 ? "a_active" : "b_active", {31'd0, id == 0 ? a_act : b_act}, {31'd0, e_act});
        chk(id == 0 ? "a_done" : "b_done", {31'd0, id == 0 ? a_done : b_done}, {31'd0, e_dn});
        chk(id == 0 ? "a_ready" : "b_ready", {31'd0, id == 0 ? a_rdy : b_rdy}, {31'd0, e_rdy});
        if (rst) begin
          m_has[id][0] = 1'b0;
          m_has[id][1] = 1'b0;
        end else if (in_valid && e_rdy) begin
          le = m_has[id][1] ? m_s[id][1] + H + m_gap[id] : -1000;
          m_s[id][0]    = m_s[id][1];
          m_code[id][0] = m_code[id][1];
          m_zero[id][0] = m_zero[id][1];
          m_has[id][0]  = m_has[id][1];
          m_s[id][1]    = (cyc + 1 > le) ? cyc + 1 : le;
          m_code[id][1] = int'(in_code);
          m_zero[id][1] = in_zero;
          m_has[id][1]  = 1'b1;
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] code;
    logic       zero;
    logic [3:0] oh;
    logic       act;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #2;
  endtask

  // Single transaction on dut_a from idle, checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    drain();
    chk("vec_accept_ready", {31'd0, a_rdy}, 32'd1);
    in_valid = 1'b1; in_code = v.code; in_zero = v.zero;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= H + GA + 1; k++) begin
      if (k <= H) begin
        chk("vec_strobe", {28'd0, a_oh}, {28'd0, v.oh});
        chk("vec_active", {31'd0, a_act}, {31'd0, v.act});
      end else if (k <= H + GA) begin
        chk("vec_gap", {28'd0, a_oh}, 32'd0);
      end else begin
        chk("vec_done", {31'd0, a_done}, 32'd1);
        chk("vec_done_ready", {31'd0, a_rdy}, 32'd1);
      end
      if (k < H + GA + 1) step();
    end
  endtask

  initial begin
    int last_acc;
    tbl[0] = '{2'b00, 1'b0, 4'b0001, 1'b1};
    tbl[1] = '{2'b01, 1'b0, 4'b0010, 1'b1};
    tbl[2] = '{2'b10, 1'b0, 4'b0100, 1'b1};
    tbl[3] = '{2'b11, 1'b0, 4'b1000, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 4'b0000, 1'b0};
    tbl[5] = '{2'b11, 1'b1, 4'b0000, 1'b0};

    // Reset held with a code offered
    rst = 1'b1; in_valid = 1'b1; in_code = 2'b10;
    repeat (3) begin
      step();
      chk("rst_onehot", {28'd0, a_oh}, 32'd0);
      chk("rst_done", {31'd0, a_done}, 32'd0);
      chk("rst_ready", {31'd0, a_rdy}, 32'd0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("ready_after_rst", {31'd0, a_rdy}, 32'd1);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset during the second strobe cycle
    drain();
    in_valid = 1'b1; in_code = 2'b11; in_zero = 1'b0;
    step();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("midhold_strobe", {28'd0, a_oh}, 32'h8);
    rst = 1'b1;
    #1;
    chk("midhold_rst_onehot", {28'd0, a_oh}, 32'd0);
    chk("midhold_rst_active", {31'd0, a_act}, 32'd0);
    repeat (2) begin
      step();
      chk("midhold_no_done", {31'd0, a_done}, 32'd0);
    end
    rst = 1'b0;
    step();
    chk("midhold_idle_ready", {31'd0, a_rdy}, 32'd1);

`ifdef PRIO_CODE_DECODER_SKID_EN
    // Two codes offered back to back into the GAP=0 instance
    drain();
    in_valid = 1'b1; in_code = 2'b01; in_zero = 1'b0;
    step();
    chk("skid_first", {28'd0, b_oh}, 32'h2);
    chk("skid_ready_hold", {31'd0, b_rdy}, 32'd1);
    in_code = 2'b10;
    step();
    in_valid = 1'b0;
    for (int k = 2; k <= 9; k++) begin
      chk("skid_strobe", {28'd0, b_oh}, k <= 4 ? 32'h2 : (k <= 8 ? 32'h4 : 32'h0));
      chk("skid_done", {31'd0, b_done}, (k == 5 || k == 9) ? 32'd1 : 32'd0);
      step();
    end
`else
    // Sweep all codes back to back; each accepted on its predecessor's done
    drain();
    last_acc = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 20 && !a_rdy; j++) step();
      chk("sweep_ready", {31'd0, a_rdy}, 32'd1);
      if (i > 0) begin
        chk("sweep_done_with_ready", {31'd0, a_done}, 32'd1);
        chk("sweep_period", cyc - last_acc, H + GA + 1);
      end
      last_acc = cyc;
      in_valid = 1'b1; in_code = 2'(i); in_zero = 1'b0;
      step();
      in_valid = 1'b0;
      chk("sweep_strobe", {28'd0, a_oh}, 32'd1 << i);
    end
`endif

    // Randomised traffic with occasional resets; the checker does the work
    drain();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = $urandom_range(0, 1) == 1;
      in_code  = 2'($urandom_range(0, 3));
      in_zero  = ($urandom_range(0, 4) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
